// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cu_pkg
// Brief    : Shared opcodes, ALU op encoding, instruction classes and FSM
//            states for the 8-bit processor control unit.
// Revision : 1.0 - initial release
// ============================================================================
package cu_pkg;

  localparam logic [3:0] c_OP_NOP = 4'h0;
  localparam logic [3:0] c_OP_LDA = 4'h1;
  localparam logic [3:0] c_OP_LDB = 4'h2;
  localparam logic [3:0] c_OP_ADD = 4'h3;
  localparam logic [3:0] c_OP_SUB = 4'h4;
  localparam logic [3:0] c_OP_AND = 4'h5;
  localparam logic [3:0] c_OP_OR  = 4'h6;
  localparam logic [3:0] c_OP_OUT = 4'h7;
  localparam logic [3:0] c_OP_JMP = 4'h8;
  localparam logic [3:0] c_OP_HLT = 4'hF;

  // 2-bit ALU operation encoding, shared with the ALU
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_LOAD = 3'd1,
    CLS_JMP  = 3'd2,
    CLS_ALU  = 3'd3,
    CLS_OUT  = 3'd4,
    CLS_HLT  = 3'd5
  } instr_class_t;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_IMM       = 3'd2,
    ST_EXEC_READ = 3'd3,
    ST_EXEC_WAIT = 3'd4,
    ST_OUT_READ  = 3'd5,
    ST_OUT_DONE  = 3'd6,
    ST_HALT      = 3'd7
  } state_t;

endpackage : cu_pkg
`default_nettype wire

// File: rtl/cu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : cu_decoder
// Brief    : Combinational opcode decoder: instruction class, two-byte flag,
//            load destination and ALU operation.
// Revision : 1.0 - initial release
// ============================================================================
module cu_decoder
  import cu_pkg::*;
(
  input  logic [3:0]   i_opcode,
  output instr_class_t o_class,
  output logic         o_two_byte,
  output logic         o_load_sel,
  output alu_op_t      o_alu_op
);

  always_comb begin
    o_class    = CLS_NOP;
    o_two_byte = 1'b0;
    o_load_sel = 1'b0;
    o_alu_op   = ALU_ADD;
    case (i_opcode)
      c_OP_LDA: begin
        o_class    = CLS_LOAD;
        o_two_byte = 1'b1;
      end
      c_OP_LDB: begin
        o_class    = CLS_LOAD;
        o_two_byte = 1'b1;
        o_load_sel = 1'b1;
      end
      c_OP_ADD: o_class = CLS_ALU;
      c_OP_SUB: begin
        o_class  = CLS_ALU;
        o_alu_op = ALU_SUB;
      end
      c_OP_AND: begin
        o_class  = CLS_ALU;
        o_alu_op = ALU_AND;
      end
      c_OP_OR: begin
        o_class  = CLS_ALU;
        o_alu_op = ALU_OR;
      end
      c_OP_OUT: o_class = CLS_OUT;
      c_OP_JMP: begin
        o_class    = CLS_JMP;
        o_two_byte = 1'b1;
      end
      c_OP_HLT: o_class = CLS_HLT;
      default:  o_class = CLS_NOP;
    endcase
  end

endmodule : cu_decoder
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Brief    : Instruction sequencer: fetches, decodes and drives register bank
//            strobes and the ALU opcode for the 8-bit processor.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit
  import cu_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       cu_clk,
  input  logic       cu_rst,
  input  logic       cu_run,
  output logic [7:0] cu_pc,
  input  logic [7:0] cu_instr_in,
  output logic [7:0] cu_data_out,
  output logic       cu_reg_selector,
  output logic       cu_reg_write_enable,
  output logic       cu_reg_read_enable,
  output logic [1:0] cu_alu_op,
  output logic       cu_out_valid,
  output logic       cu_halted
);

  state_t       r_state;
  state_t       w_state_next;
  logic [7:0]   r_pc;
  logic [7:0]   w_pc_next;
  // Only the opcode nibble of the instruction register carries meaning
  logic [3:0]   r_opcode;
  logic [3:0]   w_opcode_next;
  alu_op_t      r_alu_op;
  alu_op_t      w_alu_op_next;

  instr_class_t w_class;
  logic         w_two_byte;
  logic         w_load_sel;
  alu_op_t      w_dec_alu_op;

  logic [7:0]   w_data_out;
  logic         w_selector;
  logic         w_write_en;
  logic         w_read_en;
  logic         w_out_valid;
  logic         w_halted;

  cu_decoder u_decoder (
    .i_opcode   (r_opcode),
    .o_class    (w_class),
    .o_two_byte (w_two_byte),
    .o_load_sel (w_load_sel),
    .o_alu_op   (w_dec_alu_op)
  );

  always_ff @(posedge cu_clk) begin
    if (cu_rst) begin
      r_state  <= ST_FETCH;
      r_pc     <= PC_RESET;
      r_opcode <= 4'h0;
      r_alu_op <= ALU_ADD;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_opcode <= w_opcode_next;
      r_alu_op <= w_alu_op_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_opcode_next = r_opcode;
    w_alu_op_next = r_alu_op;
    w_data_out    = 8'h00;
    w_selector    = 1'b0;
    w_write_en    = 1'b0;
    w_read_en     = 1'b0;
    w_out_valid   = 1'b0;
    w_halted      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (cu_run) begin
          w_opcode_next = cu_instr_in[7:4];
          w_pc_next     = r_pc + 8'd1;
          w_state_next  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (w_class)
          CLS_ALU: begin
            w_alu_op_next = w_dec_alu_op;
            w_state_next  = ST_EXEC_READ;
          end
          CLS_OUT: w_state_next = ST_OUT_READ;
          CLS_HLT: w_state_next = ST_HALT;
          default: w_state_next = w_two_byte ? ST_IMM : ST_FETCH;
        endcase
      end
      ST_IMM: begin
        // JMP takes the immediate as the new pc; loads consume it as data
        if (w_class == CLS_JMP) begin
          w_pc_next = cu_instr_in;
        end else begin
          w_pc_next  = r_pc + 8'd1;
          w_data_out = cu_instr_in;
          w_write_en = 1'b1;
          w_selector = w_load_sel;
        end
        w_state_next = ST_FETCH;
      end
      ST_EXEC_READ: begin
        w_read_en    = 1'b1;
        w_state_next = ST_EXEC_WAIT;
      end
      ST_EXEC_WAIT: w_state_next = ST_FETCH;
      ST_OUT_READ: begin
        w_read_en    = 1'b1;
        w_selector   = 1'b1;
        w_state_next = ST_OUT_DONE;
      end
      ST_OUT_DONE: begin
        w_out_valid  = 1'b1;
        w_state_next = ST_FETCH;
      end
      ST_HALT: w_halted = 1'b1;
      default: w_state_next = ST_FETCH;
    endcase
  end

  assign cu_pc               = r_pc;
  assign cu_data_out         = w_data_out;
  assign cu_reg_selector     = w_selector;
  assign cu_reg_write_enable = w_write_en;
  assign cu_reg_read_enable  = w_read_en;
  assign cu_alu_op           = r_alu_op;
  assign cu_out_valid        = w_out_valid;
  assign cu_halted           = w_halted;

endmodule : control_unit
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Brief    : Directed self-checking bench for control_unit with a small
//            register bank / ALU model attached to its strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

  logic       cu_clk;
  logic       cu_rst;
  logic       cu_run;
  logic [7:0] cu_pc;
  logic [7:0] cu_instr_in;
  logic [7:0] cu_data_out;
  logic       cu_reg_selector;
  logic       cu_reg_write_enable;
  logic       cu_reg_read_enable;
  logic [1:0] cu_alu_op;
  logic       cu_out_valid;
  logic       cu_halted;

  logic [7:0] mem [256];
  int         n_checks = 0;
  int         n_err    = 0;

  // Register bank and result register model
  logic [7:0] m_a, m_b, m_out1, m_out2, m_res;

  control_unit #(.PC_RESET(8'h00)) dut (
    .cu_clk              (cu_clk),
    .cu_rst              (cu_rst),
    .cu_run              (cu_run),
    .cu_pc               (cu_pc),
    .cu_instr_in         (cu_instr_in),
    .cu_data_out         (cu_data_out),
    .cu_reg_selector     (cu_reg_selector),
    .cu_reg_write_enable (cu_reg_write_enable),
    .cu_reg_read_enable  (cu_reg_read_enable),
    .cu_alu_op           (cu_alu_op),
    .cu_out_valid        (cu_out_valid),
    .cu_halted           (cu_halted)
  );

  assign cu_instr_in = mem[cu_pc];

  initial cu_clk = 1'b0;
  always #5 cu_clk = ~cu_clk;

  function automatic logic [7:0] alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  always @(posedge cu_clk) begin
    if (cu_reg_write_enable) begin
      if (cu_reg_selector) m_b <= cu_data_out;
      else                 m_a <= cu_data_out;
    end
    if (cu_reg_read_enable) begin
      if (cu_reg_selector) m_out2 <= m_res;
      else begin
        m_out1 <= m_a;
        m_out2 <= m_b;
      end
    end
    m_res <= alu(cu_alu_op, m_out1, m_out2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cu_clk);
    #1;
  endtask

  // One clock, then compare {pc, we, re, sel, data, valid, halted}
  task automatic cyc(input string tag, input logic [7:0] pc, input logic we, input logic re,
                     input logic sel, input logic [7:0] d, input logic v, input logic h);
    tick();
    check(tag, {11'b0, cu_pc, cu_reg_write_enable, cu_reg_read_enable, cu_reg_selector,
                cu_data_out, cu_out_valid, cu_halted},
               {11'b0, pc, we, re, sel, d, v, h});
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    cu_rst = 1'b1;
    tick();
    cu_rst = 1'b0;
  endtask

  initial begin
    cu_rst = 1'b1;
    cu_run = 1'b0;
    clear_mem();

    // ADD program: LDA 05, LDB 03, ADD, OUT, HLT
    mem[0] = 8'h10; mem[1] = 8'h05; mem[2] = 8'h20; mem[3] = 8'h03;
    mem[4] = 8'h30; mem[5] = 8'h70; mem[6] = 8'hF0;
    do_reset();
    check("reset_state", {10'b0, cu_pc, cu_reg_write_enable, cu_reg_read_enable, cu_reg_selector,
                          cu_data_out, cu_out_valid, cu_halted, cu_alu_op}, 32'h0);
    cu_run = 1'b1;
    cyc("add_k1",  8'h01, 0, 0, 0, 8'h00, 0, 0);
    cyc("add_lda", 8'h01, 1, 0, 0, 8'h05, 0, 0);
    cyc("add_k3",  8'h02, 0, 0, 0, 8'h00, 0, 0);
    cyc("add_k4",  8'h03, 0, 0, 0, 8'h00, 0, 0);
    cyc("add_ldb", 8'h03, 1, 0, 1, 8'h03, 0, 0);
    cyc("add_k6",  8'h04, 0, 0, 0, 8'h00, 0, 0);
    cyc("add_k7",  8'h05, 0, 0, 0, 8'h00, 0, 0);
    cyc("add_exr", 8'h05, 0, 1, 0, 8'h00, 0, 0);
    cyc("add_exw", 8'h05, 0, 0, 0, 8'h00, 0, 0);
    cyc("add_k10", 8'h05, 0, 0, 0, 8'h00, 0, 0);
    cyc("add_k11", 8'h06, 0, 0, 0, 8'h00, 0, 0);
    cyc("add_outr",8'h06, 0, 1, 1, 8'h00, 0, 0);
    cyc("add_outd",8'h06, 0, 0, 0, 8'h00, 1, 0);
    check("add_result", m_out2, 8'h08);
    check("add_aluop", cu_alu_op, 2'b00);
    cyc("add_k14", 8'h06, 0, 0, 0, 8'h00, 0, 0);
    cyc("add_k15", 8'h07, 0, 0, 0, 8'h00, 0, 0);
    cyc("add_halt",8'h07, 0, 0, 0, 8'h00, 0, 1);
    cu_run = 1'b0;
    cyc("halt_norun", 8'h07, 0, 0, 0, 8'h00, 0, 1);
    cu_run = 1'b1;
    cyc("halt_run",   8'h07, 0, 0, 0, 8'h00, 0, 1);

    // SUB program: LDA 03, LDB 05, SUB, OUT -> 3 - 5 = FE
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h03; mem[2] = 8'h20; mem[3] = 8'h05;
    mem[4] = 8'h40; mem[5] = 8'h70;
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    check("sub_exr_re", cu_reg_read_enable, 1'b1);
    check("sub_exr_op", cu_alu_op, 2'b01);
    for (int i = 0; i < 5; i++) tick();
    check("sub_valid", cu_out_valid, 1'b1);
    check("sub_result", m_out2, 8'hFE);
    tick();
    check("sub_valid_1cyc", cu_out_valid, 1'b0);
    check("sub_op_held", cu_alu_op, 2'b01);

    // Reset abandons an instruction in EXEC_READ
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    check("mid_exr_re", cu_reg_read_enable, 1'b1);
    do_reset();
    check("mid_rst", {10'b0, cu_pc, cu_reg_write_enable, cu_reg_read_enable, cu_reg_selector,
                      cu_data_out, cu_out_valid, cu_halted, cu_alu_op}, 32'h0);
    cu_run = 1'b0;
    cyc("mid_rst_fetch", 8'h00, 0, 0, 0, 8'h00, 0, 0);
    cu_run = 1'b1;
    cyc("mid_rst_resume", 8'h01, 0, 0, 0, 8'h00, 0, 0);

    // JMP wrap: JMP 10; JMP FF; FF = NOP wraps to 00 = HLT
    clear_mem();
    mem[8'h00] = 8'h80; mem[8'h01] = 8'h10;
    mem[8'h10] = 8'h80; mem[8'h11] = 8'hFF;
    do_reset();
    cyc("jmp_k1",  8'h01, 0, 0, 0, 8'h00, 0, 0);
    cyc("jmp_imm", 8'h01, 0, 0, 0, 8'h00, 0, 0);
    cyc("jmp_to10",8'h10, 0, 0, 0, 8'h00, 0, 0);
    mem[8'h00] = 8'hF0;
    cyc("jmp_k4",  8'h11, 0, 0, 0, 8'h00, 0, 0);
    cyc("jmp_imm2",8'h11, 0, 0, 0, 8'h00, 0, 0);
    cyc("jmp_toFF",8'hFF, 0, 0, 0, 8'h00, 0, 0);
    cyc("jmp_wrap",8'h00, 0, 0, 0, 8'h00, 0, 0);
    cyc("jmp_k8",  8'h00, 0, 0, 0, 8'h00, 0, 0);
    cyc("jmp_k9",  8'h01, 0, 0, 0, 8'h00, 0, 0);
    cyc("jmp_halt",8'h01, 0, 0, 0, 8'h00, 0, 1);

    // run low in FETCH, LDA 07, undefined A0, LDB 09 with run dropped mid-way
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h07; mem[2] = 8'hA0; mem[3] = 8'h20; mem[4] = 8'h09;
    cu_run = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) cyc("stall", 8'h00, 0, 0, 0, 8'h00, 0, 0);
    cu_run = 1'b1;
    cyc("res_k1",  8'h01, 0, 0, 0, 8'h00, 0, 0);
    cyc("res_lda", 8'h01, 1, 0, 0, 8'h07, 0, 0);
    cyc("res_k3",  8'h02, 0, 0, 0, 8'h00, 0, 0);
    cyc("undef_dec",8'h03, 0, 0, 0, 8'h00, 0, 0);
    cyc("undef_done",8'h03, 0, 0, 0, 8'h00, 0, 0);
    cyc("ldb_dec", 8'h04, 0, 0, 0, 8'h00, 0, 0);
    cu_run = 1'b0;
    cyc("ldb_imm", 8'h04, 1, 0, 1, 8'h09, 0, 0);
    cyc("ldb_fetch",8'h05, 0, 0, 0, 8'h00, 0, 0);
    cyc("ldb_hold",8'h05, 0, 0, 0, 8'h00, 0, 0);
    check("lda_model", m_a, 8'h07);
    check("ldb_model", m_b, 8'h09);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_control_unit
`default_nettype wire

// File: doc/control_unit.md
# control_unit

Instruction sequencer for the 8-bit processor. Fetches byte-wide instructions from a combinational-read program memory, decodes them, and drives the register bank's write/read strobes, selector and data input plus the ALU operation code. It sits directly upstream of the register bank and commands every register transfer and ALU evaluation.

## Interface
Parameters:
- PC_RESET, 8'h00, program counter value after reset.

Ports:
- cu_clk  in  1  single clock; all state changes on rising edge.
- cu_rst  in  1  synchronous, active-high reset.
- cu_run  in  1  level enable; a low level stalls the block in FETCH.
- cu_pc  out  8  program memory address.
- cu_instr_in  in  8  program memory data at cu_pc, valid in the same cycle.
- cu_data_out  out  8  immediate operand, drives reg_data_in.
- cu_reg_selector  out  1  drives reg_selector.
- cu_reg_write_enable  out  1  drives reg_write_enable.
- cu_reg_read_enable  out  1  drives reg_read_enable.
- cu_alu_op  out  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
- cu_out_valid  out  1  one-cycle pulse; reg_data_out2 holds the result register.
- cu_halted  out  1  high while in HALT.

## Operation
- Opcode field is ir[7:4]:
  - 0 NOP, 1 LDA, 2 LDB
  - 3 ADD, 4 SUB, 5 AND, 6 OR
  - 7 OUT, 8 JMP, F HLT
  - All other opcodes execute as NOP.
- ir[3:0] is ignored.
- LDA, LDB and JMP are two bytes; the second byte is the immediate.
- State machine, Moore outputs decoded from state and ir:
  - FETCH: if cu_run, capture ir <= cu_instr_in and set pc <= pc+1; otherwise hold.
  - DECODE: branch as follows.
    - NOP/undefined -> FETCH.
    - LDA/LDB/JMP -> IMM.
    - ALU ops -> EXEC_READ; cu_alu_op is latched here.
    - OUT -> OUT_READ.
    - HLT -> HALT.
  - IMM, for LDA/LDB: cu_data_out = cu_instr_in, write_enable=1, selector=0 (LDA) or 1 (LDB); pc <= pc+1; -> FETCH.
  - IMM, for JMP: pc <= cu_instr_in, no strobes; -> FETCH.
  - EXEC_READ: read_enable=1, selector=0 (operands to reg_data_out1/2); -> EXEC_WAIT.
  - EXEC_WAIT: no strobes; the result register captures the ALU result on this cycle's closing edge; -> FETCH.
  - OUT_READ: read_enable=1, selector=1; -> OUT_DONE.
  - OUT_DONE: cu_out_valid=1; -> FETCH.
  - HALT: cu_halted=1; stays until reset; ignores cu_run.
- cu_alu_op is held after EXEC_WAIT until the next ALU instruction. The result register reloads every cycle, so the ALU output must remain stable.
- OUT routes the result register onto reg_data_out2, which changes the ALU inputs. A second OUT without an intervening ALU instruction therefore returns an undefined value; this is the documented programming rule.
- pc arithmetic is 8-bit modulo: 8'hFF+1 = 8'h00. An immediate fetched at 8'hFF wraps to 8'h00.

## Timing
- Reset (cu_rst high at an edge) sets:
  - state = FETCH, pc = PC_RESET, ir = 8'h00, cu_alu_op = 00.
  - cu_data_out = 0, all strobes 0, cu_out_valid = 0, cu_halted = 0.
- Reset has priority in every state, including mid-instruction and HALT. A partially executed instruction is abandoned without strobes.
- Cycles per instruction, with cu_run held high:
  - NOP: 2
  - LDA/LDB/JMP: 3
  - ALU: 4
  - OUT: 4
- The write strobe is valid for exactly the IMM cycle; the register bank samples on the edge ending IMM.
- cu_out_valid rises the cycle after OUT_READ. It is exactly one cycle wide.
- cu_run is sampled only in FETCH; a drop mid-instruction completes the current instruction.

## Structure
- Shared package cu_pkg holds:
  - opcode constants
  - state enumeration
  - ALU op codes
  - the 2-bit ALU op encoding, also imported by the ALU
- One sub-module, cu_decoder: combinational, maps ir to instruction class, two-byte flag and alu_op.
- FSM, pc and ir stay in control_unit.

## Test plan
- Reset mid-EXEC_READ: cu_rst high for 1 cycle -> next cycle pc=00, state FETCH, all strobes 0, cu_halted=0.
- Program 10 05, 20 03, 30, 70, F0 with bank and ALU attached:
  - write strobes at the LDA and LDB IMM cycles carry data 05 and 03.
  - cu_out_valid pulses with reg_data_out2=08.
  - cu_halted rises after 16 cycles.
- SUB program 10 03, 20 05, 40, 70: OUT returns 8'hFE (modulo-256 wrap), cu_alu_op=01 held after EXEC_WAIT.
- JMP wrap: JMP FF with FF=NOP and 00=HLT -> pc sequence FF, 00, then cu_halted=1.
- cu_run low in FETCH for 5 cycles -> pc and ir unchanged, no strobes; resume executes the next instruction normally.
- Undefined opcode A0 -> 2-cycle NOP behaviour, no strobes, pc+1.
